// File: rtl/pipeline_mem_arbiter_if.sv
// pipeline_mem_arbiter_if
// Groups the fetch requester, data requester and memory port signals of the
// unified-memory arbiter.
//   slave  : the arbiter (takes requests and memRdata, drives grants/memory).
//   master : the surroundings (fetch stage, MEM stage and the memory).
// Signals:
//   ifReq/ifAddr            fetch request and address
//   ifGnt/ifValid/ifRdata   fetch issue pulse, data-valid pulse, instruction
//   ifStall                 ifReq & ~ifValid
//   dmReq/dmWr/dmSize       data request, store flag, access size
//   dmAddr/dmWdata          data address and store data
//   dmGnt/dmValid/dmRdata   data issue pulse, done pulse, load data
//   dmStall                 dmReq & ~dmValid
//   memReq/memWr/memSize    memory issue strobe, write enable, size
//   memAddr/memWdata        memory address and write data
//   memRdata                memory read data (fixed latency after memReq)
interface pipeline_mem_arbiter_if;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        ifGnt;
  logic        ifValid;
  logic [31:0] ifRdata;
  logic        ifStall;

  logic        dmReq;
  logic        dmWr;
  logic [1:0]  dmSize;
  logic [31:0] dmAddr;
  logic [31:0] dmWdata;
  logic        dmGnt;
  logic        dmValid;
  logic [31:0] dmRdata;
  logic        dmStall;

  logic        memReq;
  logic        memWr;
  logic [1:0]  memSize;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;

  modport slave (
    input  ifReq, ifAddr,
    output ifGnt, ifValid, ifRdata, ifStall,
    input  dmReq, dmWr, dmSize, dmAddr, dmWdata,
    output dmGnt, dmValid, dmRdata, dmStall,
    output memReq, memWr, memSize, memAddr, memWdata,
    input  memRdata
  );

  modport master (
    output ifReq, ifAddr,
    input  ifGnt, ifValid, ifRdata, ifStall,
    output dmReq, dmWr, dmSize, dmAddr, dmWdata,
    input  dmGnt, dmValid, dmRdata, dmStall,
    input  memReq, memWr, memSize, memAddr, memWdata,
    output memRdata
  );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// pipeline_mem_arbiter
// Shares one fixed-latency memory port between instruction fetch and the
// load/store stage, one access outstanding at a time. Data wins ties unless
// fetch has already lost STARVE_MAX grants in a row.
// Ports:
//   clk     system clock, rising edge
//   resetN  asynchronous active-low reset
//   bus     pipeline_mem_arbiter_if.slave (requesters + memory port)
// Parameters:
//   MEM_LATENCY  cycles from memReq to valid memRdata (>= 1)
//   STARVE_MAX   consecutive data grants tolerated while fetch waits
module pipeline_mem_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic                   clk,
  input  logic                   resetN,
  pipeline_mem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   lat_q, lat_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_wr_q, mem_wr_d;
  logic [1:0]      mem_size_q, mem_size_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            if_gnt_q, if_gnt_d;
  logic            dm_gnt_q, dm_gnt_d;
  logic            if_valid_q, if_valid_d;
  logic            dm_valid_q, dm_valid_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     dm_rdata_q, dm_rdata_d;

  logic            fetch_forced;

  // Fetch overrides data only once it has been passed over STARVE_MAX times.
  assign fetch_forced = bus.ifReq && (starve_q == SW'(STARVE_MAX));

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves a variable unassigned, which would infer a latch.
    state_d     = state_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    mem_req_d   = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.dmReq && !fetch_forced) begin
          state_d     = BUSY_DM;
          lat_d       = CW'(MEM_LATENCY);
          mem_req_d   = 1'b1;
          mem_wr_d    = bus.dmWr;
          mem_size_d  = bus.dmSize;
          mem_addr_d  = bus.dmAddr;
          mem_wdata_d = bus.dmWdata;
          dm_gnt_d    = 1'b1;
          // Only count grants that actually made fetch wait; starve_q is
          // below STARVE_MAX here whenever ifReq is high, so no overflow.
          starve_d    = bus.ifReq ? starve_q + 1'b1 : '0;
        end else if (bus.ifReq) begin
          state_d     = BUSY_IF;
          lat_d       = CW'(MEM_LATENCY);
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b0;
          mem_size_d  = 2'b10;
          mem_addr_d  = bus.ifAddr;
          mem_wdata_d = '0;
          if_gnt_d    = 1'b1;
          starve_d    = '0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        // memRdata is valid in the cycle where the counter has run out,
        // MEM_LATENCY cycles after the memReq cycle.
        if (lat_q == '0) begin
          state_d = IDLE;
          if (state_q == BUSY_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = bus.memRdata;
          end else begin
            dm_valid_d = 1'b1;
            dm_rdata_d = mem_wr_q ? '0 : bus.memRdata;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state, including the data/address holding registers, is
  // reset so that every output reads 0 straight out of reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q     <= state_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign bus.ifGnt    = if_gnt_q;
  assign bus.ifValid  = if_valid_q;
  assign bus.ifRdata  = if_rdata_q;
  assign bus.ifStall  = bus.ifReq & ~if_valid_q;
  assign bus.dmGnt    = dm_gnt_q;
  assign bus.dmValid  = dm_valid_q;
  assign bus.dmRdata  = dm_rdata_q;
  assign bus.dmStall  = bus.dmReq & ~dm_valid_q;
  assign bus.memReq   = mem_req_q;
  assign bus.memWr    = mem_wr_q;
  assign bus.memSize  = mem_size_q;
  assign bus.memAddr  = mem_addr_q;
  assign bus.memWdata = mem_wdata_q;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// tb_pipeline_mem_arbiter
// Directed bench for pipeline_mem_arbiter: one instance with MEM_LATENCY=2
// and one with MEM_LATENCY=1, each attached to a small fixed-latency memory
// model whose read data is only meaningful in its valid cycle.
module tb_pipeline_mem_arbiter;

  logic clk;
  logic resetN;
  int   n_vec = 0;
  int   n_err = 0;

  pipeline_mem_arbiter_if b2();
  pipeline_mem_arbiter_if b1();

  pipeline_mem_arbiter #(.MEM_LATENCY(2), .STARVE_MAX(4)) u2 (
    .clk(clk), .resetN(resetN), .bus(b2)
  );
  pipeline_mem_arbiter #(.MEM_LATENCY(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .resetN(resetN), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
  endfunction

  // Memory models: read data appears MEM_LATENCY cycles after memReq,
  // garbage otherwise.
  logic [1:0]  p2v = 2'b00;
  logic [31:0] p2a [2];
  logic        p1v = 1'b0;
  logic [31:0] p1a;

  always @(posedge clk) begin
    p2v    <= {p2v[0], b2.memReq};
    p2a[0] <= b2.memAddr;
    p2a[1] <= p2a[0];
    p1v    <= b1.memReq;
    p1a    <= b1.memAddr;
  end

  assign b2.memRdata = p2v[1] ? mem_f(p2a[1]) : 32'hBAD0_BAD0;
  assign b1.memRdata = p1v    ? mem_f(p1a)    : 32'hBAD0_BAD0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [9:0]  exp_f;
  logic [31:0] f_addr [4];
  int          g_cnt;
  int          last;
  int          extra;
  bit          seen;
  bit          is_f;

  initial begin
    resetN = 1'b0;
    b2.ifReq = 0; b2.ifAddr = 0; b2.dmReq = 0; b2.dmWr = 0;
    b2.dmSize = 0; b2.dmAddr = 0; b2.dmWdata = 0;
    b1.ifReq = 0; b1.ifAddr = 0; b1.dmReq = 0; b1.dmWr = 0;
    b1.dmSize = 0; b1.dmAddr = 0; b1.dmWdata = 0;

    // Reset values
    #12;
    chk("rst_ctrl", {26'd0, b2.ifGnt, b2.dmGnt, b2.ifValid, b2.dmValid, b2.memReq, b2.memWr}, 32'd0);
    chk("rst_addr", b2.memAddr, 32'd0);
    chk("rst_wdata_size", b2.memWdata | {30'd0, b2.memSize}, 32'd0);
    chk("rst_rdata", b2.ifRdata | b2.dmRdata, 32'd0);
    chk("rst_starve", u2.starve_q, 32'd0);
    #10 resetN = 1'b1;

    // Single fetch 0x100, MEM_LATENCY=2; cycle 0 is this cycle
    step();
    b2.ifReq = 1; b2.ifAddr = 32'h100;
    #1 chk("fetch_stall_c0", b2.ifStall, 1);
    step();
    chk("fetch_gnt_c1", {b2.ifGnt, b2.memReq, b2.dmGnt}, 3'b110);
    chk("fetch_addr_c1", b2.memAddr, 32'h100);
    chk("fetch_wr_size_c1", {b2.memWr, b2.memSize}, 3'b010);
    chk("fetch_stall_c1", b2.ifStall, 1);
    step();
    chk("fetch_c2", {b2.ifGnt, b2.memReq, b2.ifValid, b2.ifStall}, 4'b0001);
    step();
    chk("fetch_c3", {b2.ifValid, b2.ifStall}, 2'b01);
    step();
    chk("fetch_valid_c4", {b2.ifValid, b2.ifStall}, 2'b10);
    chk("fetch_rdata_c4", b2.ifRdata, 32'hDEAD_BEEF);
    b2.ifReq = 0;
    step();
    chk("fetch_c5", {b2.ifValid, b2.ifGnt, b2.memReq}, 3'b000);
    chk("fetch_rdata_hold", b2.ifRdata, 32'hDEAD_BEEF);
    chk("fetch_addr_hold", b2.memAddr, 32'h100);

    // Store 0x12345678 -> 0x2000
    b2.dmReq = 1; b2.dmWr = 1; b2.dmSize = 2'b10;
    b2.dmAddr = 32'h2000; b2.dmWdata = 32'h1234_5678;
    step();
    chk("st_gnt", {b2.dmGnt, b2.ifGnt, b2.memReq, b2.memWr}, 4'b1011);
    chk("st_addr", b2.memAddr, 32'h2000);
    chk("st_wdata", b2.memWdata, 32'h1234_5678);
    chk("st_size", b2.memSize, 2'b10);
    b2.dmReq = 0;
    step();
    chk("st_req_one_cycle", {b2.memReq, b2.dmValid, b2.dmStall}, 3'b000);
    step();
    chk("st_c8", b2.dmValid, 0);
    step();
    chk("st_valid", b2.dmValid, 1);
    chk("st_rdata_zero", b2.dmRdata, 32'd0);

    // Both requesters held: expect D D D D F D D D D F, 4 cycles apart
    b2.ifReq = 1; b2.ifAddr = 32'h500;
    b2.dmReq = 1; b2.dmWr = 0; b2.dmSize = 2'b10; b2.dmAddr = 32'h600;
    exp_f = 10'b10_0001_0000;
    g_cnt = 0; last = 0;
    for (int c = 1; c <= 60 && g_cnt < 10; c++) begin
      step();
      if (b2.ifValid) chk("arb_if_stall_in_valid", b2.ifStall, 0);
      if (b2.dmValid) chk("arb_dm_stall_in_valid", b2.dmStall, 0);
      if (b2.ifGnt || b2.dmGnt) begin
        chk("arb_order", {b2.ifGnt, b2.dmGnt}, exp_f[g_cnt] ? 2'b10 : 2'b01);
        chk("arb_addr", b2.memAddr, exp_f[g_cnt] ? 32'h500 : 32'h600);
        if (g_cnt > 0) chk("arb_gap", c - last, 4);
        last = c;
        g_cnt++;
      end
    end
    b2.ifReq = 0; b2.dmReq = 0;
    chk("arb_count", g_cnt, 10);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (b2.ifValid) seen = 1;
    end
    chk("arb_last_valid_seen", seen, 1);
    chk("arb_last_rdata", b2.ifRdata, mem_f(32'h500));

    // Load, dmReq dropped after grant; ifReq rises in the dmValid cycle
    b2.dmReq = 1; b2.dmWr = 0; b2.dmAddr = 32'h3000;
    step();
    chk("ld_gnt", b2.dmGnt, 1);
    b2.dmReq = 0;
    step();
    step();
    chk("ld_not_yet", b2.dmValid, 0);
    step();
    chk("ld_valid", b2.dmValid, 1);
    chk("ld_rdata", b2.dmRdata, mem_f(32'h3000));
    b2.ifReq = 1; b2.ifAddr = 32'h400;
    step();
    chk("ld_then_if_gnt", {b2.ifGnt, b2.dmGnt}, 2'b10);
    chk("ld_then_if_addr", b2.memAddr, 32'h400);
    b2.ifReq = 0;
    extra = 0;
    step(); extra += int'(b2.dmGnt);
    step(); extra += int'(b2.dmGnt);
    step(); extra += int'(b2.dmGnt);
    chk("ld_then_if_valid", b2.ifValid, 1);
    chk("ld_then_if_rdata", b2.ifRdata, mem_f(32'h400));
    step(); extra += int'(b2.dmGnt | b2.memReq);
    chk("ld_no_extra_dm", extra, 0);

    // Reset one cycle after a data grant
    b2.ifReq = 1; b2.ifAddr = 32'h800;
    b2.dmReq = 1; b2.dmWr = 1; b2.dmAddr = 32'h7000; b2.dmWdata = 32'hCAFE_F00D;
    step();
    chk("rst_mid_gnt", b2.dmGnt, 1);
    b2.ifReq = 0;
    step();
    #1 resetN = 1'b0;
    #1;
    chk("rst_mid_ctrl", {26'd0, b2.ifGnt, b2.dmGnt, b2.ifValid, b2.dmValid, b2.memReq, b2.memWr}, 32'd0);
    chk("rst_mid_addr", b2.memAddr, 32'd0);
    chk("rst_mid_wdata", b2.memWdata, 32'd0);
    chk("rst_mid_rdata", b2.ifRdata | b2.dmRdata, 32'd0);
    chk("rst_mid_starve", u2.starve_q, 32'd0);
    b2.dmWr = 0;
    step();
    chk("rst_mid_no_valid", {b2.dmValid, b2.memReq}, 2'b00);
    #1 resetN = 1'b1;
    #1 chk("rst_rel_no_gnt", b2.dmGnt, 0);
    step();
    chk("rst_rel_gnt", b2.dmGnt, 1);
    chk("rst_rel_addr", b2.memAddr, 32'h7000);
    chk("rst_rel_wr", b2.memWr, 0);
    b2.dmReq = 0;
    step();
    step();
    chk("rst_rel_not_yet", b2.dmValid, 0);
    step();
    chk("rst_rel_valid", b2.dmValid, 1);
    chk("rst_rel_rdata", b2.dmRdata, mem_f(32'h7000));

    // MEM_LATENCY=1: fetch / load alternating, 3 cycles per access
    f_addr = '{32'h10, 32'h20, 32'h30, 32'h40};
    for (int i = 0; i < 4; i++) begin
      is_f = (i % 2) == 0;
      if (is_f) begin
        b1.ifReq = 1; b1.ifAddr = f_addr[i];
      end else begin
        b1.dmReq = 1; b1.dmWr = 0; b1.dmSize = 2'b01; b1.dmAddr = f_addr[i];
      end
      step();
      chk("l1_gnt", {b1.ifGnt, b1.dmGnt}, is_f ? 2'b10 : 2'b01);
      chk("l1_addr", b1.memAddr, f_addr[i]);
      chk("l1_size", b1.memSize, is_f ? 2'b10 : 2'b01);
      b1.ifReq = 0; b1.dmReq = 0;
      step();
      chk("l1_not_yet", {b1.ifValid, b1.dmValid}, 2'b00);
      step();
      chk("l1_valid", {b1.ifValid, b1.dmValid}, is_f ? 2'b10 : 2'b01);
      chk("l1_rdata", is_f ? b1.ifRdata : b1.dmRdata, mem_f(f_addr[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
